register_load_sequencer: RTL
============================

REGISTER_LOAD_SEQUENCER -- requirements
Module: register_load_sequencer

Interface
REQ-001 The block SHALL have one parameter: BYTE_TIMEOUT, default 15, the consecutive idle cycles in STREAM before an abort.
REQ-002 The block SHALL have port Clock, input, 1, the single clock; all logic is updated on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port CmdValid, input, 1, command request.
REQ-005 The block SHALL have port CmdReady, output, 1, command accept.
REQ-006 The block SHALL have port CmdOp, input, 3, opcode.
REQ-007 The block SHALL have port CmdCount, input, 4, repeat count for INC/DEC.
REQ-008 The block SHALL have port CmdData, input, 32, immediate operand.
REQ-009 The block SHALL have port ByteValid, input, 1, byte-stream valid.
REQ-010 The block SHALL have port ByteReady, output, 1, byte-stream ready.
REQ-011 The block SHALL have port ByteData, input, 8, stream byte, MSB-first.
REQ-012 The block SHALL have port RegE, output, 1, enable to the target 32-bit register.
REQ-013 The block SHALL have port RegFunSel, output, 3, function select to the target register.
REQ-014 The block SHALL have port RegI, output, 32, data to the target register.
REQ-015 The block SHALL have port Busy, output, 1, high whenever the block is not in IDLE.
REQ-016 The block SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-017 The block SHALL have port Error, output, 1, qualifies Done: illegal opcode or stream timeout.

Function
REQ-018 Opcode encodings SHALL be:
- 000 NOP.
- 001 CLEAR: FunSel 011.
- 010 LOADW: FunSel 010, RegI=CmdData.
- 011 INC: FunSel 001, repeated CmdCount times.
- 100 DEC: FunSel 000, repeated CmdCount times.
- 101 STREAM: four bytes, FunSel 110 each.
- 110 LOADSX: FunSel 111, RegI=CmdData.
- 111 illegal.
REQ-019 The block SHALL use states IDLE, EXEC, REPEAT, STREAM and FINISH, with a registered state register.
REQ-020 CmdReady SHALL be 1 only in IDLE; a command is accepted at edge T when CmdValid=1 and CmdReady=1, and CmdOp/CmdCount/CmdData SHALL be captured at that edge.
REQ-021 RegE, RegFunSel and RegI SHALL be registered outputs; RegE SHALL be 0 in every cycle in which no register operation is issued.
REQ-022 When RegE=0, RegFunSel SHALL be 000 and RegI SHALL be 0.
REQ-023 CLEAR, LOADW and LOADSX SHALL go IDLE->EXEC, with RegE=1 for exactly cycle T+1, then FINISH, with Done=1 in cycle T+2, then IDLE.
REQ-024 INC/DEC with count N>0 SHALL go IDLE->REPEAT, with RegE=1 for exactly N consecutive cycles T+1..T+N, then Done in cycle T+N+1.
REQ-025 INC/DEC with count 0 and NOP SHALL issue no RegE and SHALL go IDLE->FINISH, with Done in cycle T+1.
REQ-026 Opcode 111 SHALL issue no RegE and SHALL produce Done=1 with Error=1 in cycle T+1.
REQ-027 In STREAM, ByteReady SHALL be 1.
REQ-028 Each STREAM byte handshake at edge t SHALL produce, in cycle t+1:
- RegE=1;
- RegFunSel=110;
- RegI={24'b0, ByteData}.
REQ-029 STREAM SHALL use a 2-bit byte counter; the handshake that moves the count from 3 to 4 SHALL transition the block to FINISH, with ByteReady=0 thereafter.
REQ-030 Back-to-back bytes SHALL be accepted at one per cycle, with no bubble.
REQ-031 The timeout counter SHALL reset to 0 on entry to STREAM and on each byte handshake, and SHALL increment on each STREAM cycle without a handshake.
REQ-032 When the timeout counter reaches BYTE_TIMEOUT, the block SHALL go to FINISH, with Done=1 and Error=1 in the following cycle; bytes already shifted SHALL NOT be undone.
REQ-033 Error SHALL be 0 whenever Done is 0.
REQ-034 Done SHALL be high for exactly one cycle per accepted command.
REQ-035 Busy SHALL be 1 in EXEC, REPEAT, STREAM and FINISH, and 0 in IDLE.
REQ-036 A new command SHALL NOT be accepted during the Done cycle; the earliest next accept is the cycle after Done.
REQ-037 The repeat counter SHALL be 4 bits and loaded with CmdCount; a count of 15 SHALL yield exactly 15 RegE pulses, with no wrap.

Reset
REQ-038 Reset=1 at a rising edge SHALL set state to IDLE, clear all counters, and set CmdReady=1.
REQ-039 Reset=1 at a rising edge SHALL set ByteReady=0, RegE=0, RegFunSel=000, RegI=0, Busy=0, Done=0 and Error=0.
REQ-040 Reset asserted mid-operation, in any state, SHALL abort the operation with no further RegE, no Done pulse, and no Error.
REQ-041 Reset SHALL take priority over a simultaneous CmdValid or ByteValid; those inputs SHALL be ignored in that cycle.

Verification
REQ-042 LOADW with CmdData=0xDEADBEEF SHALL give cycle T+1 RegE=1, FunSel=010, RegI=0xDEADBEEF; cycle T+2 Done=1, Error=0, and a model register reads 0xDEADBEEF.
REQ-043 INC with count 3 on a register holding 0xFFFFFFFE SHALL give RegE=1 for 3 cycles with FunSel=001, Done at T+4, and the register reads 0x00000001 (wrap).
REQ-044 STREAM with bytes 0x12,0x34,0x56,0x78 back-to-back SHALL give 4 consecutive RegE cycles with FunSel=110, the register reads 0x12345678, and Done=1, Error=0.
REQ-045 STREAM with bytes 0xAA, 0xBB and then no ByteValid for BYTE_TIMEOUT cycles SHALL give Done=1, Error=1, and the register holds its prior value shifted left by 16 with 0xAABB in the low half.
REQ-046 Opcode 111 SHALL give no RegE and Done=1, Error=1 at T+1; INC with count 0 SHALL give Done=1, Error=0 at T+1.
REQ-047 Reset asserted during the 8th RegE cycle of DEC with count 10 SHALL give RegE=0 from the next cycle, no Done, and CmdReady=1.

Source files
------------

// File: rtl/register_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : register_load_sequencer
// Brief    : Turns opcode commands and an MSB-first byte stream into
//            enable/function-select/data operations on a 32-bit register.
// Revision : 1.0
// ============================================================================
module register_load_sequencer #(
    parameter int BYTE_TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [2:0]  CmdOp,
    input  logic [3:0]  CmdCount,
    input  logic [31:0] CmdData,
    input  logic        ByteValid,
    output logic        ByteReady,
    input  logic [7:0]  ByteData,
    output logic        RegE,
    output logic [2:0]  RegFunSel,
    output logic [31:0] RegI,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    localparam int c_tmo_w = (BYTE_TIMEOUT < 2) ? 1 : $clog2(BYTE_TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(BYTE_TIMEOUT - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);

    localparam logic [2:0] c_op_nop    = 3'b000;
    localparam logic [2:0] c_op_clear  = 3'b001;
    localparam logic [2:0] c_op_loadw  = 3'b010;
    localparam logic [2:0] c_op_inc    = 3'b011;
    localparam logic [2:0] c_op_dec    = 3'b100;
    localparam logic [2:0] c_op_stream = 3'b101;
    localparam logic [2:0] c_op_loadsx = 3'b110;

    localparam logic [2:0] c_fs_dec    = 3'b000;
    localparam logic [2:0] c_fs_inc    = 3'b001;
    localparam logic [2:0] c_fs_load   = 3'b010;
    localparam logic [2:0] c_fs_clear  = 3'b011;
    localparam logic [2:0] c_fs_shift  = 3'b110;
    localparam logic [2:0] c_fs_loadsx = 3'b111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXEC   = 3'd1,
        REPEAT = 3'd2,
        STREAM = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           rep_cnt_q, rep_cnt_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [c_tmo_w-1:0]   tmo_q, tmo_d;
    logic                 reg_e_q, reg_e_d;
    logic [2:0]           fun_sel_q, fun_sel_d;
    logic [31:0]          reg_i_q, reg_i_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 byte_ready_q, byte_ready_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        rep_cnt_d  = rep_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        reg_e_d    = 1'b0;
        fun_sel_d  = 3'b000;
        reg_i_d    = 32'h0;
        error_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (CmdValid && cmd_ready_q) begin
                    case (CmdOp)
                        c_op_nop: state_d = FINISH;
                        c_op_clear: begin
                            state_d   = EXEC;
                            reg_e_d   = 1'b1;
                            fun_sel_d = c_fs_clear;
                        end
                        c_op_loadw: begin
                            state_d   = EXEC;
                            reg_e_d   = 1'b1;
                            fun_sel_d = c_fs_load;
                            reg_i_d   = CmdData;
                        end
                        c_op_inc, c_op_dec: begin
                            if (CmdCount == 4'd0) begin
                                state_d = FINISH;
                            end else begin
                                // First pulse issues here; the counter holds pulses still owed including it.
                                state_d   = REPEAT;
                                rep_cnt_d = CmdCount;
                                reg_e_d   = 1'b1;
                                fun_sel_d = (CmdOp == c_op_inc) ? c_fs_inc : c_fs_dec;
                            end
                        end
                        c_op_stream: begin
                            state_d    = STREAM;
                            byte_cnt_d = 2'd0;
                            tmo_d      = '0;
                        end
                        c_op_loadsx: begin
                            state_d   = EXEC;
                            reg_e_d   = 1'b1;
                            fun_sel_d = c_fs_loadsx;
                            reg_i_d   = CmdData;
                        end
                        default: begin
                            state_d = FINISH;
                            error_d = 1'b1;
                        end
                    endcase
                end
            end
            EXEC: state_d = FINISH;
            REPEAT: begin
                if (rep_cnt_q > 4'd1) begin
                    reg_e_d   = 1'b1;
                    fun_sel_d = fun_sel_q;
                    rep_cnt_d = rep_cnt_q - 4'd1;
                end else begin
                    state_d   = FINISH;
                    rep_cnt_d = 4'd0;
                end
            end
            STREAM: begin
                if (ByteValid && byte_ready_q) begin
                    reg_e_d    = 1'b1;
                    fun_sel_d  = c_fs_shift;
                    reg_i_d    = {24'h0, ByteData};
                    tmo_d      = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = FINISH;
                    end
                end else if (tmo_q == c_tmo_last) begin
                    // Abort keeps whatever bytes were already shifted in.
                    state_d = FINISH;
                    error_d = 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + c_tmo_one;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        done_d       = (state_d == FINISH);
        cmd_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        byte_ready_d = (state_d == STREAM);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            rep_cnt_q    <= 4'd0;
            byte_cnt_q   <= 2'd0;
            tmo_q        <= '0;
            reg_e_q      <= 1'b0;
            fun_sel_q    <= 3'b000;
            reg_i_q      <= 32'h0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cmd_ready_q  <= 1'b1;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rep_cnt_q    <= rep_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            tmo_q        <= tmo_d;
            reg_e_q      <= reg_e_d;
            fun_sel_q    <= fun_sel_d;
            reg_i_q      <= reg_i_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cmd_ready_q  <= cmd_ready_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign CmdReady  = cmd_ready_q;
    assign ByteReady = byte_ready_q;
    assign RegE      = reg_e_q;
    assign RegFunSel = fun_sel_q;
    assign RegI      = reg_i_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Error     = error_q;

endmodule
`default_nettype wire
